// File: rtl/strela_axil_cfg_regs.sv
// STRELA CGRA control/configuration registers behind an AXI4-Lite slave.
// Write and read channels are independent, one transaction outstanding each.
module strela_axil_cfg_regs #(
    parameter int unsigned AddrWidth = 64,
    parameter int unsigned DataWidth = 64,
    parameter logic [63:0] BaseAddr  = 64'h5000_0000,
    parameter logic [63:0] WindowLen = 64'h1000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [AddrWidth-1:0]   awaddr_i,
    input  logic                   awvalid_i,
    output logic                   awready_o,
    input  logic [DataWidth-1:0]   wdata_i,
    input  logic [DataWidth/8-1:0] wstrb_i,
    input  logic                   wvalid_i,
    output logic                   wready_o,
    output logic [1:0]             bresp_o,
    output logic                   bvalid_o,
    input  logic                   bready_i,
    input  logic [AddrWidth-1:0]   araddr_i,
    input  logic                   arvalid_i,
    output logic                   arready_o,
    output logic [DataWidth-1:0]   rdata_o,
    output logic [1:0]             rresp_o,
    output logic                   rvalid_o,
    input  logic                   rready_i,
    output logic                   acc_start_o,
    output logic [63:0]            acc_src_o,
    output logic [63:0]            acc_dst_o,
    output logic [31:0]            acc_len_o,
    input  logic                   acc_done_i,
    output logic                   irq_o
);
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [2:0] SelCtrl    = 3'd0;
    localparam logic [2:0] SelStatus  = 3'd1;
    localparam logic [2:0] SelSrc     = 3'd2;
    localparam logic [2:0] SelDst     = 3'd3;
    localparam logic [2:0] SelLen     = 3'd4;
    localparam logic [2:0] SelCycles  = 3'd5;

    typedef enum logic [1:0] {W_IDLE, W_WAIT_W, W_WAIT_AW, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [11:0] aw_off_q;
    logic [63:0] w_data_q;
    logic [7:0]  w_strb_q;
    logic [1:0]  bresp_q, rresp_q;
    logic [63:0] rdata_q;
    logic        irq_en, busy, done, start_q, irq_q;
    logic [63:0] src, dst, cycles, src_new, dst_new;
    logic [31:0] len, len_new;

    logic        latch_aw, latch_w, wr_fire, wr_ok, reg_wr;
    logic [11:0] wr_off, rd_off;
    logic [63:0] wr_data, rd_val;
    logic [7:0]  wr_strb;
    logic [2:0]  wr_sel;
    logic        rd_ok, ar_hs, start_ok, done_evt, done_clr;

    always_comb begin
        w_next    = w_state;
        awready_o = 1'b0;
        wready_o  = 1'b0;
        bvalid_o  = 1'b0;
        latch_aw  = 1'b0;
        latch_w   = 1'b0;
        wr_fire   = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                awready_o = 1'b1;
                wready_o  = 1'b1;
                if (awvalid_i && wvalid_i) begin
                    wr_fire = 1'b1;
                    w_next  = W_RESP;
                end else if (awvalid_i) begin
                    latch_aw = 1'b1;
                    w_next   = W_WAIT_W;
                end else if (wvalid_i) begin
                    latch_w = 1'b1;
                    w_next  = W_WAIT_AW;
                end
            end
            W_WAIT_W: begin
                wready_o = 1'b1;
                if (wvalid_i) begin
                    wr_fire = 1'b1;
                    w_next  = W_RESP;
                end
            end
            W_WAIT_AW: begin
                awready_o = 1'b1;
                if (awvalid_i) begin
                    wr_fire = 1'b1;
                    w_next  = W_RESP;
                end
            end
            W_RESP: begin
                bvalid_o = 1'b1;
                if (bready_i) w_next = W_IDLE;
            end
        endcase
        // Readies are part of the all-zero reset state.
        if (rst_i) begin
            awready_o = 1'b0;
            wready_o  = 1'b0;
        end
    end

    assign wr_off  = (w_state == W_WAIT_W) ? aw_off_q : awaddr_i[11:0];
    assign wr_data = (w_state == W_WAIT_AW) ? w_data_q : wdata_i;
    assign wr_strb = (w_state == W_WAIT_AW) ? w_strb_q : wstrb_i;
    assign wr_ok   = (wr_off[2:0] == 3'b000) && (wr_off <= 12'h028);
    assign wr_sel  = wr_off[5:3];
    assign reg_wr  = wr_fire && wr_ok;

    assign start_ok = reg_wr && (wr_sel == SelCtrl) && wr_strb[0] && wr_data[0] && !busy;
    assign done_clr = reg_wr && (wr_sel == SelStatus) && wr_strb[0] && wr_data[1];
    assign done_evt = acc_done_i && busy;

    always_comb begin
        src_new = src;
        dst_new = dst;
        len_new = len;
        for (int i = 0; i < 8; i++) begin
            if (wr_strb[i]) begin
                src_new[i*8 +: 8] = wr_data[i*8 +: 8];
                dst_new[i*8 +: 8] = wr_data[i*8 +: 8];
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (wr_strb[i]) len_new[i*8 +: 8] = wr_data[i*8 +: 8];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_state  <= W_IDLE;
            aw_off_q <= '0;
            w_data_q <= '0;
            w_strb_q <= '0;
            bresp_q  <= RespOkay;
        end else begin
            w_state <= w_next;
            if (latch_aw) aw_off_q <= awaddr_i[11:0];
            if (latch_w) begin
                w_data_q <= wdata_i;
                w_strb_q <= wstrb_i;
            end
            if (wr_fire) bresp_q <= wr_ok ? RespOkay : RespSlvErr;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_en  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            src     <= '0;
            dst     <= '0;
            len     <= '0;
            cycles  <= '0;
            start_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            start_q <= start_ok;
            irq_q   <= done && irq_en;
            if (reg_wr && wr_sel == SelCtrl && wr_strb[0]) irq_en <= wr_data[1];
            if (reg_wr && wr_sel == SelSrc) src <= src_new;
            if (reg_wr && wr_sel == SelDst) dst <= dst_new;
            if (reg_wr && wr_sel == SelLen) len <= len_new;
            // Completion beats both a same-cycle clear and a start.
            if (done_evt) begin
                busy <= 1'b0;
                done <= 1'b1;
            end else if (start_ok) begin
                busy <= 1'b1;
                done <= 1'b0;
            end else if (done_clr) begin
                done <= 1'b0;
            end
            if (start_ok) cycles <= '0;
            else if (busy && !acc_done_i) cycles <= cycles + 64'd1;
        end
    end

    assign rd_off = araddr_i[11:0];
    assign rd_ok  = (rd_off[2:0] == 3'b000) && (rd_off <= 12'h028);
    assign ar_hs  = arvalid_i && (r_state == R_IDLE);

    always_comb begin
        rd_val = '0;
        unique case (rd_off[5:3])
            SelCtrl:   rd_val = {62'b0, irq_en, 1'b0};
            SelStatus: rd_val = {62'b0, done, busy};
            SelSrc:    rd_val = src;
            SelDst:    rd_val = dst;
            SelLen:    rd_val = {32'b0, len};
            SelCycles: rd_val = cycles;
            default:   rd_val = '0;
        endcase
        if (!rd_ok) rd_val = '0;
    end

    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE: if (arvalid_i) r_next = R_RESP;
            R_RESP: if (rready_i) r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= R_IDLE;
            rdata_q <= '0;
            rresp_q <= RespOkay;
        end else begin
            r_state <= r_next;
            if (ar_hs) begin
                rdata_q <= rd_val;
                rresp_q <= rd_ok ? RespOkay : RespSlvErr;
            end
        end
    end

    assign arready_o   = (r_state == R_IDLE) && !rst_i;
    assign rvalid_o    = (r_state == R_RESP);
    assign rdata_o     = rdata_q;
    assign rresp_o     = rresp_q;
    assign bresp_o     = bresp_q;
    assign acc_start_o = start_q;
    assign acc_src_o   = src;
    assign acc_dst_o   = dst;
    assign acc_len_o   = len;
    assign irq_o       = irq_q;

    aw_in_window: assert property (@(posedge clk_i) disable iff (rst_i)
        (awvalid_i && awready_o) |-> ((64'(awaddr_i) - BaseAddr) < WindowLen));
    ar_in_window: assert property (@(posedge clk_i) disable iff (rst_i)
        (arvalid_i && arready_o) |-> ((64'(araddr_i) - BaseAddr) < WindowLen));
endmodule
